// File: rtl/ex_lsu_req.sv
// EX-stage load/store request unit: forms bus requests, buffers stores in a small FIFO,
// and holds EX until a load's data returns. Loads drain only the stores that alias them.
module ex_lsu_req #(
    parameter int DW       = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [11:0]     memop_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     rtvalue_i,
    output logic            req_o,
    output logic            wr_o,
    output logic [1:0]      size_o,
    output logic [31:0]     addr_o,
    output logic [DW/8-1:0] wstrb_o,
    output logic [DW-1:0]   wdata_o,
    input  logic            addr_ok_i,
    input  logic            data_ok_i,
    input  logic [DW-1:0]   rdata_i,
    output logic            ld_valid_o,
    output logic [DW-1:0]   ld_rdata_o,
    output logic [$clog2(DW/8)-1:0] ld_low_o,
    output logic            adel_o,
    output logic            ades_o,
    output logic [31:0]     badvaddr_o,
    output logic            stallreq_o,
    output logic            sb_empty_o
);
    localparam int BW  = DW / 8;
    localparam int OFS = $clog2(BW);
    localparam int PW  = $clog2(SB_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, LD_ADDR = 2'd1, LD_DATA = 2'd2, ST_DRAIN = 2'd3} state_t;

    state_t            state_r, state_nxt_s;
    logic [31:0]       sb_addr_r [SB_DEPTH];
    logic [BW-1:0]     sb_strb_r [SB_DEPTH];
    logic [DW-1:0]     sb_data_r [SB_DEPTH];
    logic [1:0]        sb_size_r [SB_DEPTH];
    logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [PW:0]       count_r;
    logic [31:0]       ld_addr_r;
    logic [1:0]        ld_size_r;
    logic [OFS-1:0]    ld_lo_r, ld_low_r;
    logic              ld_valid_r, discard_r;
    logic [DW-1:0]     ld_rdata_r;
    logic [15:0]       wr_ack_cnt_r;

    logic is_load_s, is_store_s, half_s, word_s, misal_s;
    logic load_pending_s, store_ok_s, sb_full_s, enq_s, deq_s, ld_cap_s, empty_after_s;
    logic [1:0]        size_s;
    logic [3:0]        strb4_s;
    logic [31:0]       word_s32;
    logic [2:0]        half_sh_s;
    logic [BW-1:0]     strb_ent_s;
    logic [SB_DEPTH-1:0] hit_v_s, rest_v_s;
    logic              req_s, wr_s;
    logic [31:0]       addr_s;
    logic [1:0]        bus_size_s;
    logic [BW-1:0]     bus_strb_s;
    logic [DW-1:0]     bus_data_s;

    // op {swr,swl,lwr,lwl,sw,sh,sb,lw,lhu,lh,lbu,lb}
    assign is_load_s  = |{memop_i[9:8], memop_i[4:0]};
    assign is_store_s = |{memop_i[11:10], memop_i[7:5]};
    assign half_s     = memop_i[2] | memop_i[3] | memop_i[6];
    assign word_s     = memop_i[4] | memop_i[7];
    assign misal_s    = (half_s & addr_i[0]) | (word_s & (addr_i[1:0] != 2'b00));

    assign adel_o     = rst_n & valid_i & is_load_s & misal_s;
    assign ades_o     = rst_n & valid_i & is_store_s & misal_s;
    assign badvaddr_o = (adel_o | ades_o) ? addr_i : 32'd0;

    // ld_valid_r marks the cycle EX consumes the result, so the same load is not re-detected
    assign load_pending_s = rst_n & valid_i & is_load_s & ~misal_s & ~flush_i & ~ld_valid_r;
    assign store_ok_s     = rst_n & valid_i & is_store_s & ~misal_s & ~flush_i;
    assign sb_full_s      = (count_r == (PW+1)'(SB_DEPTH));
    assign enq_s          = store_ok_s & ~sb_full_s;
    assign empty_after_s  = (count_r == (PW+1)'(1)) & ~enq_s;
    assign ld_cap_s       = (state_r == LD_DATA) & data_ok_i & ~discard_r & ~flush_i;
    assign half_sh_s      = (DW == 64) ? {addr_i[2], 2'b00} : 3'b000;
    assign strb_ent_s     = BW'(strb4_s) << half_sh_s;

    // Access size and 32-bit store lane pattern
    always_comb begin
        size_s   = 2'd2;
        strb4_s  = 4'b0000;
        word_s32 = 32'd0;
        if (memop_i[0] | memop_i[1] | memop_i[5]) begin
            size_s = 2'd0;
        end else if (half_s) begin
            size_s = 2'd1;
        end else begin
            size_s = 2'd2;
        end
        if (memop_i[5]) begin
            strb4_s  = 4'b0001 << addr_i[1:0];
            word_s32 = {4{rtvalue_i[7:0]}};
        end else if (memop_i[6]) begin
            strb4_s  = 4'b0011 << addr_i[1:0];
            word_s32 = {2{rtvalue_i[15:0]}};
        end else if (memop_i[7]) begin
            strb4_s  = 4'b1111;
            word_s32 = rtvalue_i;
        end else if (memop_i[10]) begin
            strb4_s  = 4'b1111 >> (2'd3 - addr_i[1:0]);
            word_s32 = rtvalue_i >> {(2'd3 - addr_i[1:0]), 3'b000};
        end else if (memop_i[11]) begin
            strb4_s  = 4'b1111 << addr_i[1:0];
            word_s32 = rtvalue_i << {addr_i[1:0], 3'b000};
        end else begin
            strb4_s  = 4'b0000;
            word_s32 = 32'd0;
        end
    end

    // Occupied entries whose line matches the EX address; rest_v excludes the head
    always_comb begin
        hit_v_s = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            hit_v_s[i] = ({1'b0, PW'(i) - rd_ptr_r} < count_r) &&
                         (sb_addr_r[i][31:OFS] == addr_i[31:OFS]);
        end
        rest_v_s = hit_v_s;
        rest_v_s[rd_ptr_r] = 1'b0;
    end

    // Next state and bus request drive
    always_comb begin
        state_nxt_s = state_r;
        req_s       = 1'b0;
        wr_s        = 1'b0;
        deq_s       = 1'b0;
        addr_s      = 32'd0;
        bus_size_s  = 2'd0;
        bus_strb_s  = '0;
        bus_data_s  = '0;
        case (state_r)
            IDLE: begin
                if (load_pending_s) begin
                    state_nxt_s = (|hit_v_s) ? ST_DRAIN : LD_ADDR;
                end else if ((count_r != '0) || enq_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LD_ADDR: begin
                req_s      = 1'b1;
                addr_s     = ld_addr_r;
                bus_size_s = ld_size_r;
                if (addr_ok_i) begin
                    state_nxt_s = LD_DATA;
                end else if (flush_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LD_ADDR;
                end
            end
            LD_DATA: begin
                if (data_ok_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LD_DATA;
                end
            end
            ST_DRAIN: begin
                req_s      = 1'b1;
                wr_s       = 1'b1;
                addr_s     = sb_addr_r[rd_ptr_r];
                bus_size_s = sb_size_r[rd_ptr_r];
                bus_strb_s = sb_strb_r[rd_ptr_r];
                bus_data_s = sb_data_r[rd_ptr_r];
                if (addr_ok_i) begin
                    deq_s = 1'b1;
                    if (empty_after_s || (load_pending_s && !(|rest_v_s))) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Store buffer FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_addr_r[i] <= 32'd0;
                sb_strb_r[i] <= '0;
                sb_data_r[i] <= '0;
                sb_size_r[i] <= 2'd0;
            end
        end else begin
            if (enq_s) begin
                sb_addr_r[wr_ptr_r] <= {addr_i[31:OFS], {OFS{1'b0}}};
                sb_strb_r[wr_ptr_r] <= strb_ent_s;
                sb_data_r[wr_ptr_r] <= {(DW/32){word_s32}};
                sb_size_r[wr_ptr_r] <= size_s;
                wr_ptr_r            <= wr_ptr_r + PW'(1);
            end
            if (deq_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Load context, result capture and flushed-load discard
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_addr_r    <= 32'd0;
            ld_size_r    <= 2'd0;
            ld_lo_r      <= '0;
            ld_low_r     <= '0;
            ld_valid_r   <= 1'b0;
            ld_rdata_r   <= '0;
            discard_r    <= 1'b0;
            wr_ack_cnt_r <= 16'd0;
        end else begin
            if (state_r == IDLE && load_pending_s) begin
                ld_addr_r <= {addr_i[31:OFS], {OFS{1'b0}}};
                ld_size_r <= size_s;
                ld_lo_r   <= addr_i[OFS-1:0];
            end
            ld_valid_r <= ld_cap_s;
            if (ld_cap_s) begin
                ld_rdata_r <= rdata_i;
                ld_low_r   <= ld_lo_r;
            end
            if (state_r == LD_DATA && data_ok_i)
                discard_r <= 1'b0;
            else if ((state_r == LD_DATA && flush_i) || (state_r == LD_ADDR && addr_ok_i && flush_i))
                discard_r <= 1'b1;
            if (state_r != LD_DATA && data_ok_i)
                wr_ack_cnt_r <= wr_ack_cnt_r + 16'd1;
        end
    end

    assign req_o      = rst_n & req_s;
    assign wr_o       = rst_n & wr_s;
    assign addr_o     = rst_n ? addr_s : 32'd0;
    assign size_o     = rst_n ? bus_size_s : 2'd0;
    assign wstrb_o    = rst_n ? bus_strb_s : '0;
    assign wdata_o    = rst_n ? bus_data_s : '0;
    assign ld_valid_o = rst_n & ld_valid_r;
    assign ld_rdata_o = rst_n ? ld_rdata_r : '0;
    assign ld_low_o   = rst_n ? ld_low_r : '0;
    assign stallreq_o = load_pending_s | (store_ok_s & sb_full_s);
    assign sb_empty_o = rst_n ? (count_r == '0) : 1'b1;
endmodule

// File: tb/tb_ex_lsu_req.sv
// Directed bench for ex_lsu_req (DW=32, two-entry store buffer).
module tb_ex_lsu_req;
    logic        clk = 1'b0;
    logic        rst_n, flush_i, valid_i, addr_ok_i, data_ok_i;
    logic [11:0] memop_i;
    logic [31:0] addr_i, rtvalue_i, rdata_i;
    logic        req_o, wr_o, ld_valid_o, adel_o, ades_o, stallreq_o, sb_empty_o;
    logic [1:0]  size_o, ld_low_o;
    logic [31:0] addr_o, wdata_o, ld_rdata_o, badvaddr_o;
    logic [3:0]  wstrb_o;
    int total = 0;
    int bad   = 0;

    localparam logic [11:0] OP_LB = 12'h001, OP_LH = 12'h004, OP_LHU = 12'h008, OP_LW = 12'h010;
    localparam logic [11:0] OP_SB = 12'h020, OP_SH = 12'h040, OP_SW = 12'h080;
    localparam logic [11:0] OP_SWL = 12'h400, OP_SWR = 12'h800;

    ex_lsu_req #(.DW(32), .SB_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .memop_i(memop_i),
        .addr_i(addr_i), .rtvalue_i(rtvalue_i), .req_o(req_o), .wr_o(wr_o), .size_o(size_o),
        .addr_o(addr_o), .wstrb_o(wstrb_o), .wdata_o(wdata_o), .addr_ok_i(addr_ok_i),
        .data_ok_i(data_ok_i), .rdata_i(rdata_i), .ld_valid_o(ld_valid_o), .ld_rdata_o(ld_rdata_o),
        .ld_low_o(ld_low_o), .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o),
        .stallreq_o(stallreq_o), .sb_empty_o(sb_empty_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b1; memop_i = OP_LW; addr_i = 32'h100;
        rtvalue_i = 32'h0; addr_ok_i = 1'b0; data_ok_i = 1'b0; rdata_i = 32'h0;
        step(); step();
        total++; if (req_o !== 1'b0 || wr_o !== 1'b0) begin bad++; $display("FAIL reset_req req=%b wr=%b want 0 0", req_o, wr_o); end
        total++; if (stallreq_o !== 1'b0 || ld_valid_o !== 1'b0) begin bad++; $display("FAIL reset_stall stall=%b ldv=%b want 0 0", stallreq_o, ld_valid_o); end
        total++; if (sb_empty_o !== 1'b1) begin bad++; $display("FAIL reset_empty got %b want 1", sb_empty_o); end
        total++; if (addr_o !== 32'h0 || wdata_o !== 32'h0 || ld_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h want 0", addr_o, wdata_o, ld_rdata_o); end
        valid_i = 1'b0; memop_i = 12'h0; rst_n = 1'b1;
        step();
    endtask

    task automatic test_store();
        valid_i = 1'b1; memop_i = OP_SW; addr_i = 32'h8000_0004; rtvalue_i = 32'hDEAD_BEEF; #1;
        total++; if (req_o !== 1'b0 || stallreq_o !== 1'b0) begin bad++; $display("FAIL st_enq_cycle req=%b stall=%b want 0 0", req_o, stallreq_o); end
        step(); valid_i = 1'b0; memop_i = 12'h0; #1;
        for (int c = 0; c < 2; c++) begin
            total++; if (req_o !== 1'b1 || wr_o !== 1'b1 || wstrb_o !== 4'b1111) begin bad++; $display("FAIL st_req c%0d req=%b wr=%b strb=%b want 1 1 1111", c, req_o, wr_o, wstrb_o); end
            total++; if (wdata_o !== 32'hDEAD_BEEF || addr_o !== 32'h8000_0004 || size_o !== 2'd2) begin bad++; $display("FAIL st_fields c%0d data=%h addr=%h size=%0d want deadbeef 80000004 2", c, wdata_o, addr_o, size_o); end
            total++; if (sb_empty_o !== 1'b0) begin bad++; $display("FAIL st_notempty got %b want 0", sb_empty_o); end
            step();
        end
        addr_ok_i = 1'b1; #1; step(); addr_ok_i = 1'b0; #1;
        total++; if (sb_empty_o !== 1'b1 || req_o !== 1'b0) begin bad++; $display("FAIL st_drained empty=%b req=%b want 1 0", sb_empty_o, req_o); end
    endtask

    task automatic test_load();
        valid_i = 1'b1; memop_i = OP_LW; addr_i = 32'h8000_0010; #1;
        total++; if (stallreq_o !== 1'b1 || req_o !== 1'b0) begin bad++; $display("FAIL ld_detect stall=%b req=%b want 1 0", stallreq_o, req_o); end
        step();
        for (int c = 0; c < 2; c++) begin
            if (c == 1) addr_ok_i = 1'b1;
            #1;
            total++; if (req_o !== 1'b1 || wr_o !== 1'b0 || addr_o !== 32'h8000_0010 || size_o !== 2'd2 || stallreq_o !== 1'b1) begin bad++; $display("FAIL ld_addr c%0d req=%b wr=%b addr=%h size=%0d stall=%b", c, req_o, wr_o, addr_o, size_o, stallreq_o); end
            step();
        end
        addr_ok_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin data_ok_i = 1'b1; rdata_i = 32'h1234_5678; end
            #1;
            total++; if (stallreq_o !== 1'b1 || ld_valid_o !== 1'b0 || req_o !== 1'b0) begin bad++; $display("FAIL ld_wait c%0d stall=%b ldv=%b req=%b want 1 0 0", c, stallreq_o, ld_valid_o, req_o); end
            step();
        end
        data_ok_i = 1'b0; #1;
        total++; if (ld_valid_o !== 1'b1 || ld_rdata_o !== 32'h1234_5678 || ld_low_o !== 2'd0 || stallreq_o !== 1'b0) begin bad++; $display("FAIL ld_result ldv=%b rdata=%h low=%0d stall=%b want 1 12345678 0 0", ld_valid_o, ld_rdata_o, ld_low_o, stallreq_o); end
        valid_i = 1'b0; memop_i = 12'h0; step();
        total++; if (ld_valid_o !== 1'b0) begin bad++; $display("FAIL ld_pulse got %b want 0", ld_valid_o); end
    endtask

    task automatic test_misalign();
        valid_i = 1'b1; memop_i = OP_LH; addr_i = 32'h1001; #1;
        total++; if (adel_o !== 1'b1 || ades_o !== 1'b0 || badvaddr_o !== 32'h1001 || stallreq_o !== 1'b0) begin bad++; $display("FAIL adel adel=%b ades=%b bva=%h stall=%b", adel_o, ades_o, badvaddr_o, stallreq_o); end
        step();
        total++; if (req_o !== 1'b0) begin bad++; $display("FAIL adel_noreq got %b want 0", req_o); end
        memop_i = OP_SW; addr_i = 32'h1002; #1;
        total++; if (ades_o !== 1'b1 || adel_o !== 1'b0 || badvaddr_o !== 32'h1002) begin bad++; $display("FAIL ades ades=%b adel=%b bva=%h", ades_o, adel_o, badvaddr_o); end
        step();
        total++; if (sb_empty_o !== 1'b1 || req_o !== 1'b0) begin bad++; $display("FAIL ades_noenq empty=%b req=%b want 1 0", sb_empty_o, req_o); end
        memop_i = OP_SH; #1;
        total++; if (ades_o !== 1'b0) begin bad++; $display("FAIL sh_aligned ades=%b want 0", ades_o); end
        valid_i = 1'b0; memop_i = 12'h0; step(); step();
    endtask

    task automatic test_store_lanes();
        logic [11:0] ops  [5] = '{OP_SWL, OP_SWR, OP_SWL, OP_SH, OP_SB};
        logic [31:0] adrs [5] = '{32'h101, 32'h102, 32'h103, 32'h102, 32'h203};
        logic [31:0] rts  [5] = '{32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 32'h1234, 32'hA5};
        logic [3:0]  strb [5] = '{4'b0011, 4'b1100, 4'b1111, 4'b1100, 4'b1000};
        logic [31:0] dat  [5] = '{32'h0000AABB, 32'hCCDD0000, 32'hAABBCCDD, 32'h12341234, 32'hA5A5A5A5};
        for (int k = 0; k < 5; k++) begin
            valid_i = 1'b1; memop_i = ops[k]; addr_i = adrs[k]; rtvalue_i = rts[k]; #1;
            step(); valid_i = 1'b0; memop_i = 12'h0; #1;
            total++; if (req_o !== 1'b1 || wstrb_o !== strb[k] || wdata_o !== dat[k] || addr_o !== {adrs[k][31:2], 2'b00}) begin bad++; $display("FAIL lane%0d strb=%b data=%h addr=%h want %b %h %h", k, wstrb_o, wdata_o, addr_o, strb[k], dat[k], {adrs[k][31:2], 2'b00}); end
            addr_ok_i = 1'b1; #1; step(); addr_ok_i = 1'b0; #1;
        end
    endtask

    task automatic test_sb_full();
        valid_i = 1'b1; memop_i = OP_SB; addr_i = 32'h100; rtvalue_i = 32'h11; #1; step();
        addr_i = 32'h101; rtvalue_i = 32'h22; #1;
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL full_second stall=%b want 0", stallreq_o); end
        step();
        addr_i = 32'h102; rtvalue_i = 32'h33; #1;
        total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL full_third stall=%b want 1", stallreq_o); end
        total++; if (addr_o !== 32'h100 || wstrb_o !== 4'b0001 || wdata_o !== 32'h11111111) begin bad++; $display("FAIL full_head addr=%h strb=%b data=%h", addr_o, wstrb_o, wdata_o); end
        step();
        addr_ok_i = 1'b1; #1;
        total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL full_hold stall=%b want 1", stallreq_o); end
        step(); addr_ok_i = 1'b0; #1;
        total++; if (stallreq_o !== 1'b0 || wstrb_o !== 4'b0010 || wdata_o !== 32'h22222222) begin bad++; $display("FAIL full_drain1 stall=%b strb=%b data=%h", stallreq_o, wstrb_o, wdata_o); end
        step(); valid_i = 1'b0; memop_i = 12'h0; addr_ok_i = 1'b1; #1; step(); #1;
        total++; if (wstrb_o !== 4'b0100 || wdata_o !== 32'h33333333 || sb_empty_o !== 1'b0) begin bad++; $display("FAIL full_third_head strb=%b data=%h empty=%b", wstrb_o, wdata_o, sb_empty_o); end
        step(); addr_ok_i = 1'b0; #1;
        total++; if (sb_empty_o !== 1'b1 || req_o !== 1'b0) begin bad++; $display("FAIL full_empty empty=%b req=%b want 1 0", sb_empty_o, req_o); end
    endtask

    task automatic test_hazard();
        valid_i = 1'b1; memop_i = OP_SW; addr_i = 32'h20; rtvalue_i = 32'hCAFE_F00D; #1; step();
        memop_i = OP_LW; #1;
        for (int c = 0; c < 2; c++) begin
            total++; if (stallreq_o !== 1'b1 || req_o !== 1'b1 || wr_o !== 1'b1 || addr_o !== 32'h20) begin bad++; $display("FAIL haz_drain c%0d stall=%b req=%b wr=%b addr=%h", c, stallreq_o, req_o, wr_o, addr_o); end
            step();
        end
        addr_ok_i = 1'b1; #1; step(); addr_ok_i = 1'b0; #1;
        total++; if (sb_empty_o !== 1'b1 || req_o !== 1'b0 || stallreq_o !== 1'b1) begin bad++; $display("FAIL haz_idle empty=%b req=%b stall=%b want 1 0 1", sb_empty_o, req_o, stallreq_o); end
        step();
        total++; if (req_o !== 1'b1 || wr_o !== 1'b0 || addr_o !== 32'h20) begin bad++; $display("FAIL haz_load req=%b wr=%b addr=%h", req_o, wr_o, addr_o); end
        addr_ok_i = 1'b1; #1; step(); addr_ok_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'hCAFE_F00D; #1; step();
        data_ok_i = 1'b0; #1;
        total++; if (ld_valid_o !== 1'b1 || ld_rdata_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL haz_result ldv=%b rdata=%h", ld_valid_o, ld_rdata_o); end
        valid_i = 1'b0; memop_i = 12'h0; step();
    endtask

    task automatic test_flush();
        valid_i = 1'b1; memop_i = OP_LW; addr_i = 32'h40; #1; step();
        addr_ok_i = 1'b1; #1; step(); addr_ok_i = 1'b0; #1;
        total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL fl_pre stall=%b want 1", stallreq_o); end
        flush_i = 1'b1; valid_i = 1'b0; memop_i = 12'h0; #1;
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL fl_stall stall=%b want 0", stallreq_o); end
        step(); flush_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h0BAD; #1; step(); data_ok_i = 1'b0; #1;
        total++; if (ld_valid_o !== 1'b0 || req_o !== 1'b0 || ld_rdata_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL fl_discard ldv=%b req=%b rdata=%h", ld_valid_o, req_o, ld_rdata_o); end
        valid_i = 1'b1; memop_i = OP_LHU; addr_i = 32'h46; #1;
        total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL fl_newload stall=%b want 1", stallreq_o); end
        step();
        total++; if (req_o !== 1'b1 || addr_o !== 32'h44 || size_o !== 2'd1) begin bad++; $display("FAIL fl_idle req=%b addr=%h size=%0d want 1 44 1", req_o, addr_o, size_o); end
        addr_ok_i = 1'b1; #1; step(); addr_ok_i = 1'b0; data_ok_i = 1'b1; rdata_i = 32'h5555_AAAA; #1; step(); data_ok_i = 1'b0; #1;
        total++; if (ld_valid_o !== 1'b1 || ld_rdata_o !== 32'h5555_AAAA || ld_low_o !== 2'd2) begin bad++; $display("FAIL fl_after ldv=%b rdata=%h low=%0d", ld_valid_o, ld_rdata_o, ld_low_o); end
        memop_i = OP_LB; addr_i = 32'h50; step();
        flush_i = 1'b1; valid_i = 1'b0; memop_i = 12'h0; #1; step(); flush_i = 1'b0; #1;
        total++; if (req_o !== 1'b0 || stallreq_o !== 1'b0) begin bad++; $display("FAIL fl_addr req=%b stall=%b want 0 0", req_o, stallreq_o); end
        step();
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misalign();
        test_store_lanes();
        test_sb_full();
        test_hazard();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_lsu_req.md
EX_LSU_REQ -- requirements
Module: ex_lsu_req

Interface -- parameters (name, default, meaning)
REQ-001 The block SHALL have parameter DW, default 32, meaning data bus width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter SB_DEPTH, default 4, meaning store-buffer entries; legal values are powers of two, 2..8.
REQ-003 The block SHALL derive the localparams BW=DW/8 and OFS=log2(BW).

Interface -- ports (name, direction, width, meaning)
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-006 The block SHALL have port flush_i, input, 1, meaning kill the EX instruction and any outstanding load.
REQ-007 The block SHALL have port valid_i, input, 1, meaning an EX instruction is present.
REQ-008 The block SHALL have port memop_i, input, 12, meaning the one-hot memory op {swr,swl,lwr,lwl,sw,sh,sb,lw,lhu,lh,lbu,lb}, with lb at bit 0.
REQ-009 The block SHALL have port addr_i, input, 32, meaning the effective address from the ALU.
REQ-010 The block SHALL have port rtvalue_i, input, 32, meaning the store source register value.
REQ-011 The block SHALL have the bus request ports: req_o output 1; wr_o output 1; size_o output 2; addr_o output 32; wstrb_o output BW; wdata_o output DW.
REQ-012 The block SHALL have the bus response ports: addr_ok_i input 1; data_ok_i input 1; rdata_i input DW.
REQ-013 The block SHALL have the load result ports: ld_valid_o output 1 (one-cycle pulse); ld_rdata_o output DW; ld_low_o output OFS (address low bits).
REQ-014 The block SHALL have the exception ports: adel_o output 1; ades_o output 1; badvaddr_o output 32.
REQ-015 The block SHALL have the port stallreq_o, output 1, meaning hold the EX stage.
REQ-016 The block SHALL have the port sb_empty_o, output 1, meaning the store buffer holds no entries.

Function
REQ-017 Misalignment SHALL be: lh/lhu/sh when addr_i[0]=1; lw/sw when addr_i[1:0]!=0. Such loads SHALL raise adel_o and such stores SHALL raise ades_o combinationally, with badvaddr_o=addr_i.
REQ-018 A misaligned op SHALL issue no request and SHALL not enqueue.
REQ-019 Store lane selection SHALL use addr_i[OFS-1:0].
  - sb: 1 strobe bit, data byte replicated.
  - sh: 2 bits, halfword replicated.
  - sw: 4 bits.
  - swl: strobes 0001/0011/0111/1111 for low bits 0..3, shifted to the 32-bit half selected by addr_i[2] when DW=64.
  - swr: strobes 1111/1110/1100/1000 for low bits 0..3, with the same shift when DW=64.
REQ-020 Stores SHALL enqueue {aligned addr, wstrb, wdata, size} into the store buffer in the cycle valid_i and the store op are both high, provided the buffer is not full and no exception is raised.
REQ-021 A store arriving when the buffer is full SHALL set stallreq_o until an entry drains.
REQ-022 Store-buffer pointers SHALL be log2(SB_DEPTH) bits wide and wrap, with a count of log2(SB_DEPTH)+1 bits. Simultaneous enqueue and dequeue SHALL leave the count unchanged.
REQ-023 The FSM SHALL have the states IDLE, LD_ADDR, LD_DATA and ST_DRAIN.
REQ-024 In IDLE with a load pending:
  - if any buffer entry matches addr[31:OFS], the FSM SHALL go to ST_DRAIN and hold stallreq_o;
  - otherwise it SHALL go to LD_ADDR.
REQ-025 In IDLE with no load pending and the buffer not empty, the FSM SHALL go to ST_DRAIN.
REQ-026 In ST_DRAIN the block SHALL drive req_o=1, wr_o=1 and the head entry.
  - On addr_ok_i it SHALL dequeue the head.
  - It SHALL return to IDLE when empty, or when no load hazard remains.
  - Store write completion via data_ok_i SHALL be counted and otherwise ignored.
REQ-027 In LD_ADDR the block SHALL drive req_o=1, wr_o=0, addr_o={addr_i[31:OFS],OFS'b0} and size_o from the op. On addr_ok_i it SHALL go to LD_DATA.
REQ-028 In LD_DATA, data_ok_i SHALL produce ld_valid_o=1 for one cycle with rdata_i and ld_low_o registered, and the FSM SHALL return to IDLE.
REQ-029 stallreq_o SHALL be high from load detection until the ld_valid_o cycle inclusive minus one, so that the result is captured as EX advances.
REQ-030 req_o and all request fields SHALL stay stable while req_o=1 and addr_ok_i=0.
REQ-031 flush_i SHALL cancel the EX op.
  - In LD_ADDR before addr_ok_i: go to IDLE.
  - In LD_DATA: go to a discard path that waits for data_ok_i, then IDLE, without pulsing ld_valid_o; stallreq_o SHALL stay 0.
  - Buffered stores SHALL be committed, never flushed.
REQ-032 A flush and an enqueue in the same cycle SHALL not enqueue.

Reset
REQ-033 On rst_n=0 at a clock edge, the FSM SHALL go to IDLE, with pointers and count 0.
REQ-034 During reset, req_o, wr_o, ld_valid_o and stallreq_o SHALL be 0, sb_empty_o SHALL be 1, and the data outputs SHALL be 0.
REQ-035 A reset mid-transaction SHALL drop the transaction; the bus tolerates an abandoned request.

Verification
REQ-036 Store sw at 0x80000004, rt=0xDEADBEEF, DW=32 -> enqueue; next cycle req_o=1, wr_o=1, wstrb_o=1111, wdata_o=0xDEADBEEF.
REQ-037 Load lw at 0x80000010 with addr_ok_i after 2 cycles and data_ok_i after 3 -> stallreq_o high throughout; ld_valid_o is one pulse with rdata.
REQ-038 lh at 0x1001 -> adel_o=1, badvaddr_o=0x1001, no req_o.
REQ-039 SB_DEPTH=2, three consecutive sb with addr_ok_i held 0 -> third store stalls; count never exceeds 2.
REQ-040 sw to 0x20 buffered, then lw at 0x20 -> the store drains first; the load issues only after sb_empty_o=1.
REQ-041 flush_i in LD_DATA, then data_ok_i -> no ld_valid_o; FSM in IDLE.
